// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, types and helpers for the AES key schedule
//
// Purpose : key_len encodings, Nk/Nr lookup, Rcon start value, GF(2^8) xtime
//           and the key-schedule state type.
// Ports   : none (package).

package aes_pkg;

   localparam logic [1:0] KL_128    = 2'b00;
   localparam logic [1:0] KL_192    = 2'b01;
   localparam logic [1:0] KL_256    = 2'b10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_t;

   // Key length in 32-bit words; 0 flags the reserved encoding.
   function automatic logic [3:0] nk_of(input logic [1:0] key_len);
      case (key_len)
         KL_128:  nk_of = 4'd4;
         KL_192:  nk_of = 4'd6;
         KL_256:  nk_of = 4'd8;
         default: nk_of = 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] key_len);
      case (key_len)
         KL_128:  nr_of = 4'd10;
         KL_192:  nr_of = 4'd12;
         KL_256:  nr_of = 4'd14;
         default: nr_of = 4'd0;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - AES SubWord: four parallel S-box lookups on a 32-bit word
//
// Purpose : combinational byte substitution used by the key expansion.
// Ports   : aes_sbox     a [7:0] in, y [7:0] out
//           aes_sub_word word [31:0] in, sub [31:0] out

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry 0 is the leftmost byte of the literal.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX_TABLE[a];

endmodule

module aes_sub_word (
   input  logic [31:0] word,
   output logic [31:0] sub
);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a (word[8*b +: 8]),
         .y (sub[8*b +: 8])
      );
   end

endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - word-serial AES-128/192/256 key expansion with round-key file
//
// Purpose : on start, expands key_in into 4*(Nr+1) words, one word per cycle,
//           into a flop-based round-key file with a registered read port.
// Ports   : clk, rst_n (async, active-low)
//           start, key_len[1:0], key_in[255:0]   expansion request
//           busy, done, keys_valid, key_err       status
//           nr[3:0]                               round count of stored schedule
//           rd_round[3:0] in, rd_key[127:0] out   round-key read, 1-cycle latency

module aes_key_sched
   import aes_pkg::*;
#(
   parameter int MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   output logic         key_err,
   output logic [3:0]   nr,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key
);

   localparam int DEPTH = 4 * (MAX_NK + 7);

   ks_state_t   state, state_nxt;
   logic [31:0] rk_file [DEPTH];
   logic [31:0] win [8];          // win[0] = w[i-1], win[k] = w[i-1-k]
   logic [31:0] kword [8];
   logic [5:0]  idx;              // index i of the word being produced
   logic [2:0]  wrap;             // tracks i mod Nk
   logic [3:0]  nk;
   logic [7:0]  rcon;

   logic [3:0]  nk_req;
   logic        legal, accept, reject, last;
   logic [31:0] prev, back, rot, sub_in, sub_out, temp, w_new;
   logic [5:0]  rd_base;

   assign nk_req = nk_of(key_len);
   assign legal  = (nk_req != 4'd0) && (int'(nk_req) <= MAX_NK);

   always_comb begin
      for (int j = 0; j < 8; j++) kword[j] = key_in[255 - 32*j -: 32];
   end

   // ---------------- state machine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start && legal) state_nxt = ST_EXPAND;
         ST_EXPAND: if (last)           state_nxt = ST_IDLE;
         default:                       state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == ST_EXPAND);
      accept = (state == ST_IDLE) && start && legal;
      reject = (state == ST_IDLE) && start && !legal;
      // Last word index is 4*(Nr+1)-1.
      last   = (state == ST_EXPAND) && (idx == {nr, 2'b11});
   end

   // ---------------- word generator ----------------
   assign prev   = win[0];
   assign back   = win[3'(nk - 4'd1)];   // w[i-Nk]
   assign rot    = {prev[23:0], prev[31:24]};
   // One SubWord instance serves both the RotWord path and the Nk=8 mid-key path.
   assign sub_in = (wrap == 3'd0) ? rot : prev;

   aes_sub_word u_sub_word (
      .word (sub_in),
      .sub  (sub_out)
   );

   always_comb begin
      temp = prev;
      if (wrap == 3'd0)                         temp = sub_out ^ {rcon, 24'h0};
      else if (nk == 4'd8 && wrap == 3'd4)      temp = sub_out;
   end

   assign w_new = back ^ temp;

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         wrap       <= '0;
         nk         <= '0;
         rcon       <= '0;
         nr         <= '0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         key_err    <= 1'b0;
      end else begin
         done    <= last;
         key_err <= reject;
         if (accept) begin
            idx        <= 6'(nk_req);
            wrap       <= '0;
            nk         <= nk_req;
            rcon       <= RCON_INIT;
            nr         <= nr_of(key_len);
            keys_valid <= 1'b0;
         end else if (busy) begin
            idx  <= idx + 6'd1;
            wrap <= (wrap == 3'(nk - 4'd1)) ? 3'd0 : wrap + 3'd1;
            if (wrap == 3'd0) rcon <= xtime(rcon);
            if (last) keys_valid <= 1'b1;
         end
      end
   end

   // ---------------- window and round-key file ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++)     win[k]     <= '0;
         for (int j = 0; j < DEPTH; j++) rk_file[j] <= '0;
      end else if (accept) begin
         for (int k = 0; k < 8; k++)
            win[k] <= (k < int'(nk_req)) ? kword[3'(int'(nk_req) - 1 - k)] : 32'h0;
         for (int j = 0; j < MAX_NK; j++)
            if (j < int'(nk_req)) rk_file[j] <= kword[j];
      end else if (busy) begin
         win[0] <= w_new;
         for (int k = 1; k < 8; k++) win[k] <= win[k-1];
         rk_file[idx] <= w_new;
      end
   end

   // ---------------- read port ----------------
   assign rd_base = {rd_round, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             rd_key <= '0;
      else if (rd_round > nr) rd_key <= '0;
      else                    rd_key <= {rk_file[rd_base],        rk_file[rd_base + 6'd1],
                                         rk_file[rd_base + 6'd2], rk_file[rd_base + 6'd3]};
   end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - self-checking bench for aes_key_sched against a FIPS-197 style model

module tb_aes_key_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key_in = '0;
   logic         busy, done, keys_valid, key_err;
   logic [3:0]   nr;
   logic [3:0]   rd_round = 4'd0;
   logic [127:0] rd_key;

   int checks = 0;
   int errors = 0;

   logic [7:0]  sbox_m [256];
   logic [31:0] mw [64];
   int          mnr;

   localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   always #5 clk = ~clk;

   aes_key_sched #(.MAX_NK(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_len    (key_len),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .key_err    (key_err),
      .nr         (nr),
      .rd_round   (rd_round),
      .rd_key     (rd_key)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   task automatic model(input logic [255:0] key, input int kl);
      int nk, t;
      logic [31:0] tmp;
      logic [7:0]  rc;
      nk  = 4 + 2 * kl;
      mnr = nk + 6;
      t   = 4 * (mnr + 1);
      for (int i = 0; i < 64; i++) mw[i] = 32'h0;
      for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
      rc = 8'h01;
      for (int i = nk; i < t; i++) begin
         tmp = mw[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         mw[i] = mw[i-nk] ^ tmp;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int r);
      if (r > mnr) return 128'h0;
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers (called just after a falling edge) ----------------
   task automatic do_start(input logic [1:0] kl, input logic [255:0] key);
      key_len = kl;
      key_in  = key;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input int lat, input string tag);
      int n;
      bit kv_bad;
      n = 0;
      kv_bad = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
         if (!done && keys_valid) kv_bad = 1'b1;
      end
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      chk({tag, "_kv_low"}, 128'(kv_bad), 128'h0);
      chk({tag, "_busy_off"}, 128'(busy), 128'h0);
      chk({tag, "_kv_set"}, 128'(keys_valid), 128'h1);
   endtask

   task automatic read_rk(input int r, input string tag);
      rd_round = 4'(r);
      @(negedge clk);
      chk(tag, rd_key, exp_rk(r));
   endtask

   task automatic check_all(input string tag);
      for (int r = 0; r < 16; r++) read_rk(r, $sformatf("%s_r%0d", tag, r));
   endtask

   task automatic read_const(input int r, input logic [127:0] want, input string tag);
      rd_round = 4'(r);
      @(negedge clk);
      chk(tag, rd_key, want);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [255:0] ka, kb;
      int kl;
      bit kv_seen;

      build_sbox();

      repeat (2) @(negedge clk);
      chk("rst_busy", 128'(busy), 128'h0);
      chk("rst_done", 128'(done), 128'h0);
      chk("rst_kv", 128'(keys_valid), 128'h0);
      chk("rst_err", 128'(key_err), 128'h0);
      chk("rst_nr", 128'(nr), 128'h0);
      chk("rst_rdkey", rd_key, 128'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // AES-128 known vector; random LSBs must be ignored
      do_start(2'b00, {K128, 64'($urandom) << 32 | 64'($urandom), 64'($urandom)});
      chk("a128_busy", 128'(busy), 128'h1);
      wait_done(40, "a128");
      chk("a128_nr", 128'(nr), 128'd10);
      read_const(1, 128'ha0fafe1788542cb123a339392a6c7605, "a128_r1");
      read_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_r10");
      read_const(13, 128'h0, "a128_r13_zero");
      model({K128, 128'h0}, 0);
      check_all("a128");

      // reserved key_len: rejected, schedule retained
      key_len = 2'b11;
      key_in  = rand256();
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("kerr_pulse", 128'(key_err), 128'h1);
      chk("kerr_idle", 128'(busy), 128'h0);
      @(negedge clk);
      chk("kerr_clear", 128'(key_err), 128'h0);
      chk("kerr_kv", 128'(keys_valid), 128'h1);
      chk("kerr_nr", 128'(nr), 128'd10);
      read_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kerr_r10");

      // AES-192 known vector
      do_start(2'b01, {K192, 64'h0});
      wait_done(46, "a192");
      chk("a192_nr", 128'(nr), 128'd12);
      read_const(12, 128'he98ba06f448c773c8ecc720401002202, "a192_r12");

      // AES-256 known vector, then back-to-back reads 14 down to 0
      do_start(2'b10, K256);
      wait_done(52, "a256");
      chk("a256_nr", 128'(nr), 128'd14);
      read_const(14, 128'hfe4890d1e6188d0b046df344706c631e, "a256_r14");
      model(K256, 2);
      rd_round = 4'd14;
      for (int r = 14; r >= 0; r--) begin
         @(negedge clk);
         chk($sformatf("pipe_r%0d", r), rd_key, exp_rk(r));
         if (r > 0) rd_round = 4'(r - 1);
      end

      // start during EXPAND is ignored
      ka = rand256();
      kb = rand256();
      do_start(2'b00, ka);
      repeat (9) @(negedge clk);
      key_len = 2'b10;
      key_in  = kb;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("mid_no_err", 128'(key_err), 128'h0);
      wait_done(30, "mid");
      chk("mid_nr", 128'(nr), 128'd10);
      model(ka, 0);
      check_all("mid");

      // reset asserted at t0+20
      do_start(2'b00, rand256());
      kv_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (keys_valid) kv_seen = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 128'(busy), 128'h0);
      chk("mrst_kv", 128'(keys_valid), 128'h0);
      chk("mrst_nr", 128'(nr), 128'h0);
      chk("mrst_rdkey", rd_key, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_still_idle", 128'(busy), 128'h0);
      do_start(2'b00, {K128, 128'h0});
      wait_done(40, "mrst");
      chk("mrst_kv_during", 128'(kv_seen), 128'h0);
      read_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "mrst_r10");

      // back-to-back: 192 start in the done cycle of a 128 run
      do_start(2'b00, rand256());
      wait_done(40, "b2b_first");
      do_start(2'b01, {K192, 64'h0});
      chk("b2b_kv_drop", 128'(keys_valid), 128'h0);
      wait_done(46, "b2b_second");
      chk("b2b_nr", 128'(nr), 128'd12);
      read_const(12, 128'he98ba06f448c773c8ecc720401002202, "b2b_r12");
      model({K192, 64'h0}, 1);
      check_all("b2b");

      // randomized modes and keys
      for (int it = 0; it < 6; it++) begin
         kl = int'($urandom_range(0, 2));
         ka = rand256();
         do_start(2'(kl), ka);
         wait_done(28 + 3 * (4 + 2 * kl), $sformatf("rnd%0d", it));
         chk($sformatf("rnd%0d_nr", it), 128'(nr), 128'(10 + 2 * kl));
         model(ka, kl);
         check_all($sformatf("rnd%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
